// File: rtl/axi_ar_arbiter_mux_pkg.sv
// Shared AXI field widths plus the read-address interconnect types and
// arbitration-policy encodings used by the AR/AW arbiter muxes.
`ifndef AXI_FIELD_WIDTHS_DEFINED
`define AXI_FIELD_WIDTHS_DEFINED
`define ID_BITS    4
`define ADDR_WIDTH 32
`define LEN_BITS   8
`define SIZE_BITS  3
`endif

package axi_ar_arbiter_mux_pkg;

  localparam int ARB_MODE_RR    = 0;
  localparam int ARB_MODE_FIXED = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic [`ID_BITS-1:0]    id;
    logic [`ADDR_WIDTH-1:0] addr;
    logic [`LEN_BITS-1:0]   len;
    logic [`SIZE_BITS-1:0]  size;
    logic [1:0]             burst;
  } ar_payload_t;

  // Index width that still yields one bit for a degenerate single-master build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rr_arbiter.sv
// Single-cycle request arbiter: round-robin from a rotating pointer, or fixed
// priority with index 0 highest. Shared between the AR and AW muxes.
module axi_rr_arbiter
  import axi_ar_arbiter_mux_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ARB_MODE    = ARB_MODE_RR,
  localparam int IDX_W      = idx_width(NUM_MASTERS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   advance,
  output logic [NUM_MASTERS-1:0] grant_onehot,
  output logic [IDX_W-1:0]       grant_idx
);

  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] rr_ptr_d;
  logic             found;

  // First pass covers [rr_ptr, N-1]; the second pass wraps to [0, rr_ptr-1].
  // In fixed-priority mode the first pass already spans every index.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i] &&
          (ARB_MODE != ARB_MODE_RR || i >= int'(rr_ptr_q))) begin
        found           = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_idx       = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && req[i]) begin
        found           = 1'b1;
        grant_onehot[i] = 1'b1;
        grant_idx       = IDX_W'(i);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ARB_MODE == ARB_MODE_RR && advance && found) begin
      rr_ptr_d = (int'(grant_idx) == NUM_MASTERS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/axi_ar_arbiter_mux.sv
// N-to-1 AXI read-address arbiter feeding a one-entry output slot; the winner
// index is prepended to ARID so the R channel can be routed back.
module axi_ar_arbiter_mux
  import axi_ar_arbiter_mux_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W        = `ID_BITS,
  parameter int ADDR_W      = `ADDR_WIDTH,
  parameter int LEN_W       = `LEN_BITS,
  parameter int SIZE_W      = `SIZE_BITS,
  parameter int ARB_MODE    = ARB_MODE_RR,
  localparam int IDX_W      = idx_width(NUM_MASTERS)
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic [NUM_MASTERS*ID_W-1:0]   s_arid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MASTERS*LEN_W-1:0]  s_arlen,
  input  logic [NUM_MASTERS*SIZE_W-1:0] s_arsize,
  input  logic [NUM_MASTERS*2-1:0]      s_arburst,
  input  logic [NUM_MASTERS-1:0]        s_arvalid,
  output logic [NUM_MASTERS-1:0]        s_arready,
  output logic [ID_W+IDX_W-1:0]         m_arid,
  output logic [ADDR_W-1:0]             m_araddr,
  output logic [LEN_W-1:0]              m_arlen,
  output logic [SIZE_W-1:0]             m_arsize,
  output logic [1:0]                    m_arburst,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [NUM_MASTERS-1:0]        m_rgrnt
);

  slot_state_e            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [SIZE_W-1:0]      size_q, size_d;
  logic [1:0]             burst_q, burst_d;
  logic [NUM_MASTERS-1:0] rgrnt_q, rgrnt_d;

  logic                   can_accept;
  logic                   accept;
  logic [NUM_MASTERS-1:0] grant_onehot;
  logic [IDX_W-1:0]       grant_idx;

  // The slot refills in the same cycle it drains, so s_arready follows
  // m_arready combinationally. Gating with ARESETn keeps every master
  // stalled while reset is held.
  assign can_accept = (state_q == SLOT_EMPTY) || m_arready;
  assign accept     = ARESETn && can_accept && (|s_arvalid);
  assign s_arready  = accept ? grant_onehot : '0;

  axi_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .ARB_MODE    (ARB_MODE)
  ) u_arb (
    .clk          (ACLK),
    .rst_n        (ARESETn),
    .req          (s_arvalid),
    .advance      (accept),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    rgrnt_d = rgrnt_q;
    if (accept) begin
      state_d = SLOT_FULL;
      idx_d   = grant_idx;
      rgrnt_d = grant_onehot;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (grant_onehot[i]) begin
          id_d    = s_arid[i*ID_W +: ID_W];
          addr_d  = s_araddr[i*ADDR_W +: ADDR_W];
          len_d   = s_arlen[i*LEN_W +: LEN_W];
          size_d  = s_arsize[i*SIZE_W +: SIZE_W];
          burst_d = s_arburst[i*2 +: 2];
        end
      end
    end else if (state_q == SLOT_FULL && m_arready) begin
      state_d = SLOT_EMPTY;
      rgrnt_d = '0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= SLOT_EMPTY;
      idx_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      rgrnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      rgrnt_q <= rgrnt_d;
    end
  end

  assign m_arvalid = (state_q == SLOT_FULL);
  assign m_arid    = {idx_q, id_q};
  assign m_araddr  = addr_q;
  assign m_arlen   = len_q;
  assign m_arsize  = size_q;
  assign m_arburst = burst_q;
  assign m_rgrnt   = rgrnt_q;

endmodule

// File: tb/tb_axi_ar_arbiter_mux.sv
// Scoreboard bench for axi_ar_arbiter_mux: four instances (3-master RR,
// 3-master fixed priority, 2-master RR, 8-master RR) run in parallel.
module tb_axi_ar_arbiter_mux;
  import axi_ar_arbiter_mux_pkg::*;

  localparam int IDW   = 4;
  localparam int AW    = 32;
  localparam int LW    = 8;
  localparam int SW    = 3;
  localparam int NINST = 4;

  typedef struct packed {
    logic [3:0]  idx;
    ar_payload_t pl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  for (genvar g = 0; g < NINST; g++) begin : g_inst
    localparam int N    = (g == 2) ? 2 : (g == 3) ? 8 : 3;
    localparam int MODE = (g == 1) ? ARB_MODE_FIXED : ARB_MODE_RR;
    localparam int IW   = idx_width(N);

    logic              rst_n;
    logic [N*IDW-1:0]  s_arid;
    logic [N*AW-1:0]   s_araddr;
    logic [N*LW-1:0]   s_arlen;
    logic [N*SW-1:0]   s_arsize;
    logic [N*2-1:0]    s_arburst;
    logic [N-1:0]      s_arvalid;
    logic [N-1:0]      s_arready;
    logic [IW+IDW-1:0] m_arid;
    logic [AW-1:0]     m_araddr;
    logic [LW-1:0]     m_arlen;
    logic [SW-1:0]     m_arsize;
    logic [1:0]        m_arburst;
    logic              m_arvalid;
    logic              m_arready;
    logic [N-1:0]      m_rgrnt;

    axi_ar_arbiter_mux #(
      .NUM_MASTERS (N),
      .ID_W        (IDW),
      .ADDR_W      (AW),
      .LEN_W       (LW),
      .SIZE_W      (SW),
      .ARB_MODE    (MODE)
    ) dut (
      .ACLK      (clk),
      .ARESETn   (rst_n),
      .s_arid    (s_arid),
      .s_araddr  (s_araddr),
      .s_arlen   (s_arlen),
      .s_arsize  (s_arsize),
      .s_arburst (s_arburst),
      .s_arvalid (s_arvalid),
      .s_arready (s_arready),
      .m_arid    (m_arid),
      .m_araddr  (m_araddr),
      .m_arlen   (m_arlen),
      .m_arsize  (m_arsize),
      .m_arburst (m_arburst),
      .m_arvalid (m_arvalid),
      .m_arready (m_arready),
      .m_rgrnt   (m_rgrnt)
    );

    // Reference model: each master holds at most one request until granted.
    ar_payload_t       pl [N];
    logic [N-1:0]      pending;
    exp_t              sbq [$];
    bit                mdl_full;
    int                mdl_ptr;
    int                last_win;
    logic [N-1:0]      last_grant;
    exp_t              mon_e;
    logic [IW+IDW-1:0] mon_id;

    function automatic int pick(input logic [N-1:0] p, input int start);
      for (int k = 0; k < N; k++) begin
        int c;
        c = (start + k) % N;
        if (p[c]) return c;
      end
      return -1;
    endfunction

    task automatic apply();
      for (int i = 0; i < N; i++) begin
        s_arid[i*IDW +: IDW]  = pl[i].id;
        s_araddr[i*AW +: AW]  = pl[i].addr;
        s_arlen[i*LW +: LW]   = pl[i].len;
        s_arsize[i*SW +: SW]  = pl[i].size;
        s_arburst[i*2 +: 2]   = pl[i].burst;
      end
      s_arvalid = pending;
    endtask

    task automatic drive(input logic [N-1:0] want, input bit rdy, input bit drop);
      int           w;
      logic [N-1:0] exp_rdy;
      bit           full_now;
      exp_t         e;
      @(negedge clk);
      if (last_win >= 0) pending[last_win] = 1'b0;
      last_win = -1;
      for (int i = 0; i < N; i++) begin
        if (drop && pending[i] && $urandom_range(0, 15) == 0) pending[i] = 1'b0;
        if (want[i] && !pending[i]) begin
          pending[i]  = 1'b1;
          pl[i].id    = 4'($urandom);
          pl[i].addr  = $urandom;
          pl[i].len   = 8'($urandom);
          pl[i].size  = 3'($urandom);
          pl[i].burst = 2'($urandom);
        end
      end
      apply();
      m_arready = rdy;
      full_now  = mdl_full;
      exp_rdy   = '0;
      if ((!mdl_full || rdy) && (|pending)) begin
        w          = pick(pending, (MODE == ARB_MODE_FIXED) ? 0 : mdl_ptr);
        exp_rdy[w] = 1'b1;
        e.idx      = 4'(w);
        e.pl       = pl[w];
        sbq.push_back(e);
        mdl_full   = 1'b1;
        mdl_ptr    = (w + 1) % N;
        last_win   = w;
      end else if (mdl_full && rdy) begin
        mdl_full = 1'b0;
      end
      #1;
      chk($sformatf("i%0d s_arready", g), s_arready, exp_rdy);
      chk($sformatf("i%0d m_arvalid", g), m_arvalid, full_now);
      if (!full_now) chk($sformatf("i%0d m_rgrnt_empty", g), m_rgrnt, 0);
      last_grant = s_arready;
    endtask

    task automatic start();
      rst_n     = 1'b0;
      pending   = '0;
      for (int i = 0; i < N; i++) pl[i] = '0;
      apply();
      m_arready = 1'b0;
      mdl_full  = 1'b0;
      mdl_ptr   = 0;
      last_win  = -1;
      s_arvalid = '1;
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("i%0d reset m_arvalid", g), m_arvalid, 0);
      chk($sformatf("i%0d reset m_rgrnt", g), m_rgrnt, 0);
      chk($sformatf("i%0d reset s_arready", g), s_arready, 0);
      s_arvalid = '0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
    endtask

    task automatic random_phase(input int cycles);
      repeat (cycles) drive(N'($urandom), $urandom_range(0, 3) != 0, 1'b1);
      repeat (N + 4) drive('0, 1'b1, 1'b0);
      chk($sformatf("i%0d drain", g), sbq.size(), 0);
    endtask

    // Monitor: the scoreboard head is always the request currently in the slot.
    always begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && m_arvalid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk($sformatf("i%0d unexpected_valid", g), m_arvalid, 0);
        end else begin
          mon_e  = sbq[0];
          mon_id = {IW'(mon_e.idx), mon_e.pl.id};
          chk($sformatf("i%0d m_arid", g), m_arid, mon_id);
          chk($sformatf("i%0d m_araddr", g), m_araddr, mon_e.pl.addr);
          chk($sformatf("i%0d m_arlen", g), m_arlen, mon_e.pl.len);
          chk($sformatf("i%0d m_arsize", g), m_arsize, mon_e.pl.size);
          chk($sformatf("i%0d m_arburst", g), m_arburst, mon_e.pl.burst);
          chk($sformatf("i%0d m_rgrnt", g), m_rgrnt, N'(1) << mon_e.idx);
          if (m_arready) void'(sbq.pop_front());
        end
      end
    end

    if (g == 0) begin : g_script
      initial begin
        start();
        for (int k = 0; k < 6; k++) begin
          drive('1, 1'b1, 1'b0);
          chk($sformatf("rr_order_%0d", k), last_grant, N'(1) << (k % 3));
        end
        repeat (4) drive('0, 1'b1, 1'b0);
        pl[1]      = '0;
        pl[1].addr = 32'h1000;
        pl[1].id   = 4'd2;
        pending[1] = 1'b1;
        drive('0, 1'b1, 1'b0);
        chk("single_s_arready", last_grant, 3'b010);
        #5;
        chk("single_m_arvalid", m_arvalid, 1);
        chk("single_m_araddr", m_araddr, 32'h1000);
        chk("single_m_arid", m_arid, 6'h12);
        chk("single_m_rgrnt", m_rgrnt, 3'b010);
        drive('0, 1'b1, 1'b0);
        drive('1, 1'b1, 1'b0);
        chk("bp_fill", last_grant, 3'b100);
        for (int k = 0; k < 5; k++) begin
          drive('1, 1'b0, 1'b0);
          chk($sformatf("bp_stall_%0d", k), last_grant, 0);
        end
        drive('1, 1'b1, 1'b0);
        chk("bp_release", last_grant, 3'b001);
        drive('1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid m_arvalid", m_arvalid, 0);
        chk("rst_mid s_arready", s_arready, 0);
        chk("rst_mid m_rgrnt", m_rgrnt, 0);
        sbq.delete();
        mdl_full = 1'b0;
        mdl_ptr  = 0;
        last_win = -1;
        #4;
        rst_n = 1'b1;
        drive('1, 1'b1, 1'b0);
        chk("rst_first_grant", last_grant, 3'b001);
        random_phase(300);
        n_done++;
      end
    end else if (g == 1) begin : g_script
      initial begin
        start();
        for (int k = 0; k < 4; k++) begin
          drive(3'b101, 1'b1, 1'b0);
          chk($sformatf("fp_m0_%0d", k), last_grant, 3'b001);
        end
        for (int k = 0; k < 3; k++) begin
          drive(3'b100, 1'b1, 1'b0);
          chk($sformatf("fp_m2_%0d", k), last_grant, 3'b100);
        end
        random_phase(300);
        n_done++;
      end
    end else begin : g_script
      initial begin
        start();
        random_phase(400);
        n_done++;
      end
    end
  end

  initial begin
    int waited;
    waited = 0;
    while (n_done < NINST && waited < 20000) begin
      @(posedge clk);
      waited++;
    end
    chk("all_instances_done", n_done, NINST);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
